router_aurora_system: RTL and testbench

// - Top of the 4-lane router test system, on a single user_clk domain.
// - Contains a source BRAM, a packet router, a 4-lane serial link (TX serializer + RX aligner) and an arbiter that writes received words into a destination BRAM.
// - A request copies the source word at router_scr_addr over the link (external loopback TX->RX) into the destination BRAM at router_dst_addr.

---
 rtl/router_link_pkg.sv | 39 +++
 rtl/lane_rx_align.sv | 120 ++++++++++++
 rtl/router_aurora_system.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_aurora_system.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_link_pkg
// Description : Shared constants, header/control codes, router FSM state
//               type and source-BRAM init pattern for the 4-lane router
//               link system.
// Revision    : 1.0 - initial release
// ============================================================================
package router_link_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 16;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = LANES * LANE_W;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;
  localparam int HDR_W      = 2;
  localparam int FRAME_LEN  = HDR_W + LANE_W;

  localparam logic [HDR_W-1:0]  HDR_DATA  = 2'b01;
  localparam logic [HDR_W-1:0]  HDR_CTRL  = 2'b10;
  localparam logic [LANE_W-1:0] IDLE_CODE = 16'h7800;
  localparam logic [LANE_W-1:0] SOF_CODE  = 16'hF0F0;
  localparam logic [31:0]       SRC_TAG   = 32'hA5A5_A5A5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_SEND    = 2'd3
  } router_state_e;

  // Content of the source BRAM: a fixed tag in the upper half, address below.
  function automatic logic [DATA_W-1:0] src_init_word(input logic [ADDR_W-1:0] a);
    return {SRC_TAG, {(DATA_W - 32 - ADDR_W){1'b0}}, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_rx_align.sv
`default_nettype none
// ============================================================================
// Module      : lane_rx_align
// Description : Per-lane serial deserialiser with header-based framing.
//               Shifts in one bit per cycle, checks the 2-bit sync header at
//               each frame boundary, slips the boundary by one bit on an
//               invalid header while unlocked, and tracks lock state.
// Ports       : clk, rst (sync active-high), rx_bit (serial in);
//               frame_valid (1-cycle pulse per boundary), hdr, payload,
//               locked.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_rx_align
  import router_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  output logic              frame_valid,
  output logic [HDR_W-1:0]  hdr,
  output logic [LANE_W-1:0] payload,
  output logic              locked
);

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int VCNT_W = $clog2(LOCK_CNT + 1);
  localparam int ICNT_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [VCNT_W-1:0] VCNT_LAST  = VCNT_W'(LOCK_CNT - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST  = ICNT_W'(UNLOCK_CNT - 1);

  logic [FRAME_LEN-2:0] sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VCNT_W-1:0]    vcnt_q, vcnt_d;
  logic [ICNT_W-1:0]    icnt_q, icnt_d;
  logic                 fv_q, fv_d;
  logic [HDR_W-1:0]     hdr_q, hdr_d;
  logic [LANE_W-1:0]    pl_q, pl_d;
  logic                 locked_q, locked_d;

  logic [FRAME_LEN-1:0] frame_w;
  logic                 hdr_ok;

  // Full frame as it stands once the current bit is included.
  assign frame_w = {sr_q, rx_bit};
  assign hdr_ok  = (frame_w[FRAME_LEN-1 -: HDR_W] == HDR_DATA) ||
                   (frame_w[FRAME_LEN-1 -: HDR_W] == HDR_CTRL);

  always_comb begin
    sr_d     = {sr_q[FRAME_LEN-3:0], rx_bit};
    cnt_d    = (cnt_q == FRAME_LAST) ? '0 : cnt_q + CNT_W'(1);
    vcnt_d   = vcnt_q;
    icnt_d   = icnt_q;
    fv_d     = 1'b0;
    hdr_d    = hdr_q;
    pl_d     = pl_q;
    locked_d = locked_q;
    if (cnt_q == FRAME_LAST) begin
      fv_d  = 1'b1;
      hdr_d = frame_w[FRAME_LEN-1 -: HDR_W];
      pl_d  = frame_w[LANE_W-1:0];
      if (hdr_ok) begin
        icnt_d = '0;
        if (!locked_q) begin
          if (vcnt_q == VCNT_LAST) begin
            locked_d = 1'b1;
            vcnt_d   = '0;
          end else begin
            vcnt_d = vcnt_q + VCNT_W'(1);
          end
        end
      end else begin
        vcnt_d = '0;
        if (locked_q) begin
          // A locked lane tolerates a few bad headers without moving its
          // boundary; losing lock never slips by itself.
          if (icnt_q == ICNT_LAST) begin
            locked_d = 1'b0;
            icnt_d   = '0;
          end else begin
            icnt_d = icnt_q + ICNT_W'(1);
          end
        end else begin
          // Holding the counter at the last position delays the next
          // boundary check by one bit: that is the slip.
          cnt_d = cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      vcnt_q   <= '0;
      icnt_q   <= '0;
      fv_q     <= 1'b0;
      hdr_q    <= '0;
      pl_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      vcnt_q   <= vcnt_d;
      icnt_q   <= icnt_d;
      fv_q     <= fv_d;
      hdr_q    <= hdr_d;
      pl_q     <= pl_d;
      locked_q <= locked_d;
    end
  end

  assign frame_valid = fv_q;
  assign hdr         = hdr_q;
  assign payload     = pl_q;
  assign locked      = locked_q;

endmodule
`default_nettype wire

// File: rtl/router_aurora_system.sv
`default_nettype none
// ============================================================================
// Module      : router_aurora_system
// Description : 4-lane router test system on one clock. A request copies a
//               source-BRAM word through a framed serial link (TX serializer
//               -> external loopback -> per-lane RX aligners) into a
//               destination BRAM via the receive arbiter.
// Ports       : user_clk, reset_pb (sync, whole block), pma_init (sync, lane
//               logic); GT_SERIAL_TX_txp/txn out, GT_SERIAL_RX_rxp/rxn in;
//               channel_up; router_start_req, router_scr_addr,
//               router_dst_addr in; router_done, dst_addr,
//               data_arbiter_recv out.
// Revision    : 1.0 - initial release
// ============================================================================
module router_aurora_system
  import router_link_pkg::*;
(
  input  logic              user_clk,
  input  logic              reset_pb,
  input  logic              pma_init,
  output logic [LANES-1:0]  GT_SERIAL_TX_txp,
  output logic [LANES-1:0]  GT_SERIAL_TX_txn,
  input  logic [LANES-1:0]  GT_SERIAL_RX_rxp,
  input  logic [LANES-1:0]  GT_SERIAL_RX_rxn,
  output logic              channel_up,
  input  logic              router_start_req,
  input  logic [ADDR_W-1:0] router_scr_addr,
  input  logic [ADDR_W-1:0] router_dst_addr,
  output logic              router_done,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] data_arbiter_recv
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]     FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [FRAME_LEN-1:0] IDLE_FRAME = {HDR_CTRL, IDLE_CODE};
  localparam int DEPTH = 1 << ADDR_W;

  // Link status
  logic [LANES-1:0] lane_locked;
  logic             channel_up_q, channel_up_d;

  // TX serializer
  logic [CNT_W-1:0]                 tx_cnt_q, tx_cnt_d;
  logic [LANES-1:0][FRAME_LEN-1:0]  tx_sh_q, tx_sh_d;
  logic                             frame_load, load_sof, load_data;

  // Router FSM
  router_state_e     state_q, state_d;
  logic              req_prev_q, req_prev_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // RX side
  logic [LANES-1:0]              rx_fv;
  logic [LANES-1:0][HDR_W-1:0]   rx_hdr;
  logic [LANES-1:0][LANE_W-1:0]  rx_pl;
  logic [DATA_W-1:0]             rx_word;
  logic                          all_ctrl, all_data, sof_rest_zero, is_sof, is_data;

  // Arbiter
  logic              sof_pend_q, sof_pend_d;
  logic [ADDR_W-1:0] pend_dst_q, pend_dst_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0] recv_q, recv_d;
  logic              wr_fire, wr_q, wr_d, done_q, done_d;

  logic [DATA_W-1:0] dst_mem [DEPTH] = '{default: '0};

  logic unused_rxn;
  assign unused_rxn = ^GT_SERIAL_RX_rxn;

  // --------------------------------------------------------------------------
  // RX lanes. They are held in reset by pma_init together with the TX
  // serializer, so under zero-delay loopback both start framing on the same
  // cycle and lock without slipping.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_rx_align u_rx (
      .clk         (user_clk),
      .rst         (pma_init),
      .rx_bit      (GT_SERIAL_RX_rxp[k]),
      .frame_valid (rx_fv[k]),
      .hdr         (rx_hdr[k]),
      .payload     (rx_pl[k]),
      .locked      (lane_locked[k])
    );
  end

  assign rx_word = rx_pl;

  // --------------------------------------------------------------------------
  // TX serializer and router FSM
  // --------------------------------------------------------------------------
  always_comb begin
    frame_load = (tx_cnt_q == FRAME_LAST);
    load_sof   = frame_load && (state_q == ST_WAIT_TX) && channel_up_q;
    load_data  = frame_load && (state_q == ST_SEND) && channel_up_q;
    tx_cnt_d   = frame_load ? '0 : tx_cnt_q + CNT_W'(1);
    tx_sh_d    = tx_sh_q;
    for (int k = 0; k < LANES; k++) begin
      if (!frame_load) begin
        tx_sh_d[k] = {tx_sh_q[k][FRAME_LEN-2:0], 1'b0};
      end else if (load_sof) begin
        if (k == 0)      tx_sh_d[k] = {HDR_CTRL, SOF_CODE};
        else if (k == 1) tx_sh_d[k] = {HDR_CTRL, LANE_W'(dst_q)};
        else             tx_sh_d[k] = {HDR_CTRL, {LANE_W{1'b0}}};
      end else if (load_data) begin
        tx_sh_d[k] = {HDR_DATA, rd_data_q[k*LANE_W +: LANE_W]};
      end else begin
        tx_sh_d[k] = IDLE_FRAME;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rd_data_d  = rd_data_q;
    req_prev_d = router_start_req;
    case (state_q)
      ST_IDLE: begin
        if (channel_up_q && router_start_req && !req_prev_q) begin
          src_d   = router_scr_addr;
          dst_d   = router_dst_addr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rd_data_d = src_init_word(src_q);
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: if (frame_load) state_d = ST_SEND;
      ST_SEND:    if (frame_load) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (!channel_up_q) state_d = ST_IDLE;
  end

  // --------------------------------------------------------------------------
  // Receive arbiter. All lanes frame in lockstep, so a boundary is taken as
  // the moment every lane reports one.
  // --------------------------------------------------------------------------
  always_comb begin
    all_ctrl      = 1'b1;
    all_data      = 1'b1;
    sof_rest_zero = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      all_ctrl = all_ctrl & (rx_hdr[k] == HDR_CTRL);
      all_data = all_data & (rx_hdr[k] == HDR_DATA);
      if (k >= 2) sof_rest_zero = sof_rest_zero & (rx_pl[k] == '0);
    end
    is_sof  = (&rx_fv) && all_ctrl && (rx_pl[0] == SOF_CODE) &&
              (rx_pl[1][LANE_W-1:ADDR_W] == '0) && sof_rest_zero;
    is_data = (&rx_fv) && all_data;

    sof_pend_d   = sof_pend_q;
    pend_dst_d   = pend_dst_q;
    dst_addr_d   = dst_addr_q;
    recv_d       = recv_q;
    wr_fire      = 1'b0;
    channel_up_d = (&lane_locked) & ~pma_init;

    if (!channel_up_q) begin
      sof_pend_d = 1'b0;
    end else if (&rx_fv) begin
      if (is_sof) begin
        sof_pend_d = 1'b1;
        pend_dst_d = rx_pl[1][ADDR_W-1:0];
      end else if (is_data && sof_pend_q) begin
        wr_fire    = 1'b1;
        dst_addr_d = pend_dst_q;
        recv_d     = rx_word;
        sof_pend_d = 1'b0;
      end else begin
        sof_pend_d = 1'b0;
      end
    end
    wr_d   = wr_fire;
    done_d = wr_q;
  end

  // Lane-level TX state follows pma_init only, so idles keep flowing while
  // the rest of the block sits in reset_pb.
  always_ff @(posedge user_clk) begin
    if (pma_init) begin
      tx_cnt_q <= '0;
      tx_sh_q  <= {LANES{IDLE_FRAME}};
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset_pb) begin
      channel_up_q <= 1'b0;
      state_q      <= ST_IDLE;
      req_prev_q   <= 1'b0;
      src_q        <= '0;
      dst_q        <= '0;
      rd_data_q    <= '0;
      sof_pend_q   <= 1'b0;
      pend_dst_q   <= '0;
      dst_addr_q   <= '0;
      recv_q       <= '0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      channel_up_q <= channel_up_d;
      state_q      <= state_d;
      req_prev_q   <= req_prev_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rd_data_q    <= rd_data_d;
      sof_pend_q   <= sof_pend_d;
      pend_dst_q   <= pend_dst_d;
      dst_addr_q   <= dst_addr_d;
      recv_q       <= recv_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
    end
  end

  // Destination BRAM write port; contents survive reset.
  always_ff @(posedge user_clk) begin
    if (wr_fire && !reset_pb) dst_mem[pend_dst_q] <= rx_word;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_txout
    assign GT_SERIAL_TX_txp[k] = tx_sh_q[k][FRAME_LEN-1];
    assign GT_SERIAL_TX_txn[k] = ~tx_sh_q[k][FRAME_LEN-1];
  end

  assign channel_up        = channel_up_q;
  assign router_done       = done_q;
  assign dst_addr          = dst_addr_q;
  assign data_arbiter_recv = recv_q;

endmodule
`default_nettype wire

// File: tb/tb_router_aurora_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_aurora_system
// Description : Self-checking bench for router_aurora_system with TX looped
//               back to RX, a table of transfers and hand-written sequences
//               for abort, busy-request and header-corruption cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_aurora_system;
  import router_link_pkg::*;

  logic              user_clk = 1'b0;
  logic              reset_pb, pma_init;
  logic [LANES-1:0]  txp, txn, rxp, rxn;
  logic              channel_up, router_start_req, router_done;
  logic [ADDR_W-1:0] router_scr_addr, router_dst_addr, dst_addr;
  logic [DATA_W-1:0] data_arbiter_recv;

  always #5 user_clk = ~user_clk;

  // Bench-side frame phase: index of the bit currently on the wire.
  int   ph;
  logic corrupt;
  always @(posedge user_clk) begin
    if (pma_init) ph <= 0;
    else          ph <= (ph == FRAME_LEN - 1) ? 0 : ph + 1;
  end

  // Loopback; optionally flip lane 2 on the header MSB.
  assign rxp = txp ^ ((corrupt && ph == 0) ? 4'b0100 : 4'b0000);
  assign rxn = ~rxp;

  router_aurora_system dut (
    .user_clk          (user_clk),
    .reset_pb          (reset_pb),
    .pma_init          (pma_init),
    .GT_SERIAL_TX_txp  (txp),
    .GT_SERIAL_TX_txn  (txn),
    .GT_SERIAL_RX_rxp  (rxp),
    .GT_SERIAL_RX_rxn  (rxn),
    .channel_up        (channel_up),
    .router_start_req  (router_start_req),
    .router_scr_addr   (router_scr_addr),
    .router_dst_addr   (router_dst_addr),
    .router_done       (router_done),
    .dst_addr          (dst_addr),
    .data_arbiter_recv (data_arbiter_recv)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int compl_bad = 0;
  logic track_drop = 1'b0;
  logic drop_seen = 1'b0;

  always @(negedge user_clk) begin
    if (txn !== ~txp) compl_bad++;
    if (router_done === 1'b1) done_cnt++;
    if (track_drop && channel_up !== 1'b1) drop_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_chan(input int limit);
    int n = 0;
    while (channel_up !== 1'b1 && n < limit) begin
      @(negedge user_clk);
      n++;
    end
  endtask

  task automatic wait_ph(input int p);
    int n = 0;
    @(negedge user_clk);
    while (ph != p && n < 40) begin
      @(negedge user_clk);
      n++;
    end
  endtask

  // Raise the request for 'hold' cycles and watch 100 cycles for done.
  task automatic xfer(input logic [9:0] s, input logic [9:0] d, input int hold,
                      output int lat, output int ndone);
    int d0;
    d0  = done_cnt;
    lat = -1;
    @(negedge user_clk);
    router_scr_addr  = s;
    router_dst_addr  = d;
    router_start_req = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge user_clk);
      if (n == hold) router_start_req = 1'b0;
      if (router_done === 1'b1 && lat < 0) lat = n;
    end
    ndone = done_cnt - d0;
  endtask

  // Corrupt the next n lane-2 headers.
  task automatic corrupt_frames(input int n);
    wait_ph(1);
    corrupt = 1'b1;
    repeat (n * FRAME_LEN) @(negedge user_clk);
    corrupt = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  src;
    logic [9:0]  dst;
    int          hold;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, nd, d0;

    vecs[0] = '{src: 10'd1,   dst: 10'd5,   hold: 2, exp: 64'hA5A5A5A5_00000001};
    vecs[1] = '{src: 10'd0,   dst: 10'd6,   hold: 1, exp: 64'hA5A5A5A5_00000000};
    vecs[2] = '{src: 10'd2,   dst: 10'd7,   hold: 1, exp: 64'hA5A5A5A5_00000002};
    vecs[3] = '{src: 10'd1023, dst: 10'd1023, hold: 3, exp: 64'hA5A5A5A5_000003FF};
    vecs[4] = '{src: 10'd512, dst: 10'd0,   hold: 1, exp: 64'hA5A5A5A5_00000200};

    reset_pb = 1'b1;
    pma_init = 1'b1;
    corrupt = 1'b0;
    router_start_req = 1'b0;
    router_scr_addr = '0;
    router_dst_addr = '0;

    repeat (128) @(negedge user_clk);
    pma_init = 1'b0;
    repeat (256) @(negedge user_clk);
    chk("rst_channel_up", {63'd0, channel_up}, 64'd0);
    chk("rst_done", {63'd0, router_done}, 64'd0);
    chk("rst_dst_addr", {54'd0, dst_addr}, 64'd0);
    chk("rst_data", data_arbiter_recv, 64'd0);
    reset_pb = 1'b0;
    wait_chan(400);
    chk("initial_channel_up", {63'd0, channel_up}, 64'd1);

    // Table of transfers, each ~300 cycles apart.
    for (int i = 0; i < 5; i++) begin
      xfer(vecs[i].src, vecs[i].dst, vecs[i].hold, lat, nd);
      chk($sformatf("v%0d_latency_ok", i), {63'd0, (lat > 0 && lat <= 64)}, 64'd1);
      chk($sformatf("v%0d_done_count", i), 64'(nd), 64'd1);
      chk($sformatf("v%0d_dst_addr", i), {54'd0, dst_addr}, {54'd0, vecs[i].dst});
      chk($sformatf("v%0d_data", i), data_arbiter_recv, vecs[i].exp);
      chk($sformatf("v%0d_dst_mem", i), dut.dst_mem[vecs[i].dst], vecs[i].exp);
      repeat (200) @(negedge user_clk);
    end

    // Second rising edge while busy is ignored.
    d0 = done_cnt;
    @(negedge user_clk);
    router_scr_addr = 10'd3;
    router_dst_addr = 10'd8;
    router_start_req = 1'b1;
    @(negedge user_clk); router_start_req = 1'b0;
    @(negedge user_clk);
    @(negedge user_clk); router_start_req = 1'b1;
    @(negedge user_clk); router_start_req = 1'b0;
    repeat (150) @(negedge user_clk);
    chk("busy_done_count", 64'(done_cnt - d0), 64'd1);
    chk("busy_data", data_arbiter_recv, 64'hA5A5A5A5_00000003);

    // pma_init asserted during SEND.
    wait_ph(5);
    router_scr_addr = 10'd4;
    router_dst_addr = 10'd9;
    router_start_req = 1'b1;
    @(negedge user_clk); router_start_req = 1'b0;
    wait_ph(0);
    wait_ph(8);
    d0 = done_cnt;
    pma_init = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    chk("abort_channel_down", {63'd0, channel_up}, 64'd0);
    repeat (20) @(negedge user_clk);
    pma_init = 1'b0;
    wait_chan(400);
    chk("abort_relock", {63'd0, channel_up}, 64'd1);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_dst_mem", dut.dst_mem[9], 64'd0);
    xfer(10'd5, 10'd10, 1, lat, nd);
    chk("post_abort_done", 64'(nd), 64'd1);
    chk("post_abort_data", data_arbiter_recv, 64'hA5A5A5A5_00000005);

    // One corrupted header: lock holds.
    drop_seen = 1'b0;
    track_drop = 1'b1;
    corrupt_frames(1);
    repeat (40) @(negedge user_clk);
    track_drop = 1'b0;
    chk("one_bad_hdr_no_drop", {63'd0, drop_seen}, 64'd0);

    // Four consecutive corrupted headers: channel drops, then relocks.
    corrupt_frames(4);
    repeat (24) @(negedge user_clk);
    chk("four_bad_hdr_drop", {63'd0, channel_up}, 64'd0);
    wait_chan(400);
    chk("corrupt_relock", {63'd0, channel_up}, 64'd1);
    xfer(10'd6, 10'd11, 1, lat, nd);
    chk("post_relock_data", data_arbiter_recv, 64'hA5A5A5A5_00000006);

    // reset_pb mid-operation: outputs clear, BRAM contents stay.
    @(negedge user_clk);
    reset_pb = 1'b1;
    repeat (4) @(negedge user_clk);
    chk("rst2_dst_addr", {54'd0, dst_addr}, 64'd0);
    chk("rst2_data", data_arbiter_recv, 64'd0);
    chk("rst2_channel_up", {63'd0, channel_up}, 64'd0);
    reset_pb = 1'b0;
    chk("rst2_mem_kept", dut.dst_mem[5], 64'hA5A5A5A5_00000001);
    wait_chan(400);
    chk("rst2_channel_up_back", {63'd0, channel_up}, 64'd1);

    chk("txp_txn_compl_violations", 64'(compl_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
